// File: rtl/add_round_key_sched.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule: XORs each accepted state with the
// current round key and then advances the key one round. Optional `ARK_RK_DEBUG_EN adds rk_dbg.
module add_round_key_sched #(
  parameter int WORD_SIZE  = 8,
  parameter int ARRAY_SIZE = 16,
  parameter int NR         = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_load,
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0]   key_in,
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0]   state_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [WORD_SIZE*ARRAY_SIZE-1:0]   state_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0]                        round_idx,
  output logic                              last_round,
  output logic [4*WORD_SIZE-1:0]            sub_word_in,
  input  logic [4*WORD_SIZE-1:0]            sub_word_out
`ifdef ARK_RK_DEBUG_EN
  ,
  output logic [WORD_SIZE*ARRAY_SIZE-1:0]   rk_dbg
`endif
);

  localparam int          SW     = WORD_SIZE * ARRAY_SIZE;
  localparam int          CW     = 4 * WORD_SIZE;
  localparam logic [3:0]  NR_IDX = 4'(NR);
  localparam logic [WORD_SIZE-1:0] RCON_INIT = WORD_SIZE'(1);

  typedef enum logic {S_NOKEY, S_RUN} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [SW-1:0]        cipher_key;
  logic [SW-1:0]        round_key;
  logic [SW-1:0]        next_key;
  logic [3:0]           rk_cnt;
  logic [WORD_SIZE-1:0] rcon;
  logic                 accept;
  logic [CW-1:0]        col0, col1, col2, col3;
  logic [CW-1:0]        n0, n1, n2, n3;

  // A column word carries row 0 in its most significant byte.
  function automatic logic [CW-1:0] get_col(input logic [SW-1:0] s, input int c);
    logic [CW-1:0] w;
    w = '0;
    for (int r = 0; r < 4; r++)
      w[(3-r)*WORD_SIZE +: WORD_SIZE] = s[r*CW + c*WORD_SIZE +: WORD_SIZE];
    return w;
  endfunction

  function automatic logic [SW-1:0] put_cols(input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                                             input logic [CW-1:0] w2, input logic [CW-1:0] w3);
    logic [SW-1:0]  s;
    logic [CW-1:0]  w;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       w = w0;
        1:       w = w1;
        2:       w = w2;
        default: w = w3;
      endcase
      for (int r = 0; r < 4; r++)
        s[r*CW + c*WORD_SIZE +: WORD_SIZE] = w[(3-r)*WORD_SIZE +: WORD_SIZE];
    end
    return s;
  endfunction

  function automatic logic [WORD_SIZE-1:0] xtime(input logic [WORD_SIZE-1:0] b);
    return {b[WORD_SIZE-2:0], 1'b0} ^ (b[WORD_SIZE-1] ? WORD_SIZE'(8'h1b) : '0);
  endfunction

  // Key expansion for the next round; SubWord is supplied by the shared S-box in the same cycle.
  always_comb begin
    col0        = get_col(round_key, 0);
    col1        = get_col(round_key, 1);
    col2        = get_col(round_key, 2);
    col3        = get_col(round_key, 3);
    sub_word_in = {col3[CW-WORD_SIZE-1:0], col3[CW-1 -: WORD_SIZE]};
    n0          = col0 ^ sub_word_out ^ {rcon, {(CW-WORD_SIZE){1'b0}}};
    n1          = col1 ^ n0;
    n2          = col2 ^ n1;
    n3          = col3 ^ n2;
    next_key    = put_cols(n0, n1, n2, n3);
  end

  assign in_ready = (fsm_q == S_RUN) & ~key_load & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_NOKEY;
    else     fsm_q <= fsm_d;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    if (key_load) fsm_d = S_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cipher_key <= '0;
      round_key  <= '0;
      rk_cnt     <= '0;
      rcon       <= RCON_INIT;
      state_out  <= '0;
      out_valid  <= 1'b0;
      round_idx  <= '0;
      last_round <= 1'b0;
    end else if (key_load) begin
      // A reload restarts the schedule and discards any output still waiting.
      cipher_key <= key_in;
      round_key  <= key_in;
      rk_cnt     <= '0;
      rcon       <= RCON_INIT;
      out_valid  <= 1'b0;
    end else if (accept) begin
      state_out  <= state_in ^ round_key;
      out_valid  <= 1'b1;
      round_idx  <= rk_cnt;
      last_round <= (rk_cnt == NR_IDX);
      if (rk_cnt == NR_IDX) begin
        round_key <= cipher_key;
        rk_cnt    <= '0;
        rcon      <= RCON_INIT;
      end else begin
        round_key <= next_key;
        rk_cnt    <= rk_cnt + 4'd1;
        rcon      <= xtime(rcon);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARK_RK_DEBUG_EN
  always_ff @(posedge clk) begin
    if (rst)                       rk_dbg <= '0;
    else if (!key_load && accept)  rk_dbg <= round_key;
  end
`endif

endmodule

// File: tb/tb_add_round_key_sched.sv
// Self-checking bench for add_round_key_sched: FIPS-197 directed vectors, scoreboard queue
// filled on acceptance and drained by an independent output monitor.
module tb_add_round_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic [127:0] state_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_out;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   round_idx;
  logic         last_round;
  logic [31:0]  sub_word_in;
  logic [31:0]  sub_word_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t sb[$];

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] STATE_A = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] OUT_A0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] STATE_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] OUT_B0  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] RK_B1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  localparam logic [127:0] RK_A [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  assign sub_word_out = {SBOX[sub_word_in[31:24]], SBOX[sub_word_in[23:16]],
                         SBOX[sub_word_in[15:8]],  SBOX[sub_word_in[7:0]]};

  add_round_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .key_load     (key_load),
    .key_in       (key_in),
    .state_in     (state_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .state_out    (state_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .round_idx    (round_idx),
    .last_round   (last_round),
    .sub_word_in  (sub_word_in),
    .sub_word_out (sub_word_out)
  );

  always #5 clk = ~clk;

  // FIPS-197 hex (column words, row 0 first) into the byte (r,c) at [r*32+c*8] layout.
  function automatic logic [127:0] pack(input logic [127:0] w);
    logic [127:0] s;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r*32 + c*8 +: 8] = w[(15 - (c*4 + r))*8 +: 8];
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offers one state; entered and left just after a rising edge.
  task automatic send(input logic [127:0] st_fips, input logic [127:0] exp_fips, input int idx);
    int waited;
    in_valid = 1'b1;
    state_in = pack(st_fips);
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{data: pack(exp_fips), idx: 4'(idx), last: (idx == 10)});
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 20) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready never rose for round %0d", idx);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_key(input logic [127:0] k_fips);
    key_load = 1'b1;
    key_in   = pack(k_fips);
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  // Output monitor: every handshake on the output side is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {127'd0, out_valid}, 128'd0);
        end else begin
          e = sb.pop_front();
          check("state_out",  state_out,  e.data);
          check("round_idx",  round_idx,  e.idx);
          check("last_round", last_round, e.last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; state_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state_out",  state_out,  0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_round_idx",  round_idx,  0);
    check("rst_last_round", last_round, 0);
    check("rst_in_ready",   in_ready,   0);

    // No key yet: offered states are refused.
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("nokey_in_ready",  in_ready,  0);
      check("nokey_out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;

    // FIPS-197 round 0, then the full schedule with zero states exposing each key.
    load_key(KEY_A);
    send(STATE_A, OUT_A0, 0);
    for (int i = 1; i <= 10; i++) send('0, RK_A[i], i);
    send('0, RK_A[0], 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Back-pressure: output held, input refused, key not advanced.
    out_ready = 1'b0;
    send('0, RK_A[1], 1);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready",  in_ready,  0);
      check("stall_out_valid", out_valid, 1);
      check("stall_state_out", state_out, pack(RK_A[1]));
      check("stall_round_idx", round_idx, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send('0, RK_A[2], 2);
    send('0, RK_A[3], 3);

    // Key reload collides with an offered state at round 4.
    in_valid = 1'b1;
    state_in = pack(STATE_A);
    key_load = 1'b1;
    key_in   = pack(KEY_B);
    @(negedge clk);
    check("reload_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reload_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(STATE_B, OUT_B0, 0);
    send('0, RK_B1, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a block at round 6.
    load_key(KEY_A);
    for (int i = 0; i <= 5; i++) send('0, RK_A[i], i);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_state_out",  state_out,  0);
      check("mid_rst_out_valid",  out_valid,  0);
      check("mid_rst_round_idx",  round_idx,  0);
      check("mid_rst_last_round", last_round, 0);
      check("mid_rst_in_ready",   in_ready,   0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    load_key(KEY_A);
    send(STATE_A, OUT_A0, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
